// File: rtl/glip_jtag_out_arbiter_pkg.sv
// Shared types and helpers for the JTAG output-stream arbiter.
// Holds the arbiter state encoding, the channel-index width derivation and
// the header word pack/unpack helpers. The host-side demux uses the same helpers.
package glip_jtag_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        BURST  = 2'd2
    } arb_state_e;

    // Width of a channel index; a single-channel build still needs one bit.
    function automatic int ch_w(input int num_ch);
        return (num_ch <= 1) ? 1 : $clog2(num_ch);
    endfunction

    // Header word layout: len in the upper bits, channel index in the low ch_w_i bits.
    function automatic logic [31:0] hdr_pack(input logic [31:0] len,
                                             input logic [31:0] ch,
                                             input int          ch_w_i);
        return (len << ch_w_i) | (ch & ((32'd1 << ch_w_i) - 32'd1));
    endfunction

    function automatic logic [31:0] hdr_len(input logic [31:0] word, input int ch_w_i);
        return word >> ch_w_i;
    endfunction

    function automatic logic [31:0] hdr_ch(input logic [31:0] word, input int ch_w_i);
        return word & ((32'd1 << ch_w_i) - 32'd1);
    endfunction

endpackage

// File: rtl/glip_jtag_out_arbiter_if.sv
// Bundle between the per-channel output FIFOs, the arbiter and the JTAG
// output FSM's FIFO port. The master side is the arbiter. The slave side is
// the surrounding FIFOs/FSM.
interface glip_jtag_out_arbiter_if
    import glip_jtag_pkg::*;
#(
    parameter int WORD_WIDTH = 16,
    parameter int NUM_CH     = 4
);
    localparam int CH_W = ch_w(NUM_CH);

    logic [NUM_CH*WORD_WIDTH-1:0] in_data;
    logic [NUM_CH-1:0]            in_valid;
    logic [NUM_CH-1:0]            in_ready;
    logic [NUM_CH*WORD_WIDTH-1:0] in_level;
    logic [WORD_WIDTH-1:0]        out_data;
    logic                         out_valid;
    logic                         out_ready;
    logic [CH_W-1:0]              cur_ch;
    logic                         burst_done;

    modport master (
        input  in_data, in_valid, in_level, out_ready,
        output in_ready, out_data, out_valid, cur_ch, burst_done
    );

    modport slave (
        output in_data, in_valid, in_level, out_ready,
        input  in_ready, out_data, out_valid, cur_ch, burst_done
    );

endinterface

// File: rtl/glip_jtag_out_arbiter_rr_pick.sv
// Combinational round-robin picker. It returns the first requesting index
// found when searching upward from last+1, wrapping modulo NUM_CH.
module glip_rr_pick
    import glip_jtag_pkg::*;
#(
    parameter int NUM_CH = 4,
    localparam int CH_W  = ch_w(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   last,
    output logic [CH_W-1:0]   gnt_idx,
    output logic              gnt_any
);

    logic [CH_W-1:0] cand;

    // Scan NUM_CH candidates starting just after the previous winner.
    always_comb begin
        // NOTE: every signal written here gets a default first; a path that skips an assignment would infer a latch.
        gnt_idx = '0;
        gnt_any = 1'b0;
        cand    = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            cand = CH_W'((int'(last) + i) % NUM_CH);
            if (!gnt_any && req[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
    end

endmodule

// File: rtl/glip_jtag_out_arbiter.sv
// Round-robin arbiter that shares the JTAG output stream between NUM_CH
// channels. Each grant emits a {len, ch} header followed by exactly len
// payload words. Payload passes through combinationally. A grant is never
// truncated or preempted, except by reset.
module glip_jtag_out_arbiter
    import glip_jtag_pkg::*;
#(
    parameter int WORD_WIDTH = 16,
    parameter int NUM_CH     = 4,
    parameter int MAX_BURST  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    glip_jtag_out_arbiter_if.master  bus
);

    localparam int CH_W  = ch_w(NUM_CH);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [WORD_WIDTH-1:0] MAX_LEVEL = WORD_WIDTH'(MAX_BURST);

    arb_state_e       state_q, state_d;
    logic [CH_W-1:0]  cur_ch_q, cur_ch_d;
    logic [CH_W-1:0]  last_q, last_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [NUM_CH-1:0]     req;
    logic [CH_W-1:0]       pick_idx;
    logic                  pick_any;
    logic [WORD_WIDTH-1:0] pick_level;
    logic [WORD_WIDTH-1:0] cur_data;
    logic                  cur_valid;
    logic                  xfer;

    // A channel requests whenever its FIFO reports a non-zero level.
    always_comb begin
        req = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            req[c] = |bus.in_level[c*WORD_WIDTH +: WORD_WIDTH];
        end
    end

    glip_rr_pick #(.NUM_CH(NUM_CH)) u_pick (
        .req     (req),
        .last    (last_q),
        .gnt_idx (pick_idx),
        .gnt_any (pick_any)
    );

    assign pick_level = bus.in_level[int'(pick_idx)*WORD_WIDTH +: WORD_WIDTH];
    assign cur_data   = bus.in_data[int'(cur_ch_q)*WORD_WIDTH +: WORD_WIDTH];
    assign cur_valid  = bus.in_valid[cur_ch_q];
    assign xfer       = cur_valid & bus.out_ready;
    assign bus.cur_ch = cur_ch_q;

    // State and grant registers; an asynchronous reset returns every output to idle at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cur_ch_q <= '0;
            last_q   <= CH_W'(NUM_CH - 1);
            len_q    <= '0;
            cnt_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples pre-edge values.
            state_q  <= state_d;
            cur_ch_q <= cur_ch_d;
            last_q   <= last_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state logic, header generation and payload pass-through.
    always_comb begin
        state_d        = state_q;
        cur_ch_d       = cur_ch_q;
        last_d         = last_q;
        len_d          = len_q;
        cnt_d          = cnt_q;
        bus.out_data   = '0;
        bus.out_valid  = 1'b0;
        bus.in_ready   = '0;
        bus.burst_done = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    // The length is frozen here; later level changes cannot alter the promised burst.
                    cur_ch_d = pick_idx;
                    len_d    = (pick_level > MAX_LEVEL) ? CNT_W'(MAX_BURST)
                                                        : pick_level[CNT_W-1:0];
                    state_d  = HEADER;
                end
            end

            HEADER: begin
                bus.out_valid = 1'b1;
                bus.out_data  = WORD_WIDTH'(hdr_pack(32'(len_q), 32'(cur_ch_q), CH_W));
                if (bus.out_ready) begin
                    cnt_d   = '0;
                    state_d = BURST;
                end
            end

            BURST: begin
                bus.out_data           = cur_data;
                bus.out_valid          = cur_valid;
                bus.in_ready[cur_ch_q] = xfer;
                if (xfer) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == len_q - CNT_W'(1)) begin
                        bus.burst_done = 1'b1;
                        last_d         = cur_ch_q;
                        state_d        = IDLE;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

endmodule
